projection_scheduler: RTL

Sequencer for the tracklet projection pipeline. At each bunch crossing (BX) it walks the tracklet memory, asserting one read per clock. It tracks every issued tracklet through the fixed-latency projection calculation and generates write address and write enable for the projection memory. It also enforces the per-BX time budget: a new `bx_start` truncates the BX in progress, and the new BX is queued behind the drain.

---
 rtl/projection_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/projection_scheduler.sv
// Tracklet-read sequencer for the projection pipeline: walks the tracklet memory per BX,
// tracks reads through the fixed-latency calculator and drives projection memory writes.
module projection_scheduler #(
  parameter int ADDR_BITS    = 9,
  parameter int MEM_LATENCY  = 1,
  parameter int CALC_LATENCY = 6,
  parameter int BX_BITS      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bx_start,
  input  logic [ADDR_BITS-1:0] n_tracklets,
  input  logic [BX_BITS-1:0]   bx_in,
  output logic [ADDR_BITS-1:0] read_tracklet,
  output logic                 rd_en,
  output logic                 calc_valid,
  output logic [ADDR_BITS-1:0] write_projection,
  output logic                 wr_en,
  output logic [BX_BITS-1:0]   bx_out,
  output logic                 busy,
  output logic                 done,
  output logic                 truncated,
  output logic [ADDR_BITS-1:0] n_proj
);
  localparam int L = MEM_LATENCY + CALC_LATENCY;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] n_q, n_d;
  logic [ADDR_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_BITS-1:0] pend_n_q, pend_n_d;
  logic [BX_BITS-1:0]   pend_bx_q, pend_bx_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 trunc_q, trunc_d;
  logic [L-1:0]         vld_q, vld_d;
  logic [ADDR_BITS-1:0] read_tracklet_q, read_tracklet_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0] write_projection_q, write_projection_d;
  logic [BX_BITS-1:0]   bx_out_q, bx_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 truncated_q, truncated_d;
  logic [ADDR_BITS-1:0] n_proj_q, n_proj_d;
  logic                 load;
  logic [ADDR_BITS-1:0] ld_n;
  logic [BX_BITS-1:0]   ld_bx;

  always_comb begin
    state_d            = state_q;
    n_d                = n_q;
    pend_n_d           = pend_n_q;
    pend_bx_d          = pend_bx_q;
    pend_vld_d         = pend_vld_q;
    trunc_d            = trunc_q;
    rd_en_d            = 1'b0;
    read_tracklet_d    = read_tracklet_q;
    bx_out_d           = bx_out_q;
    done_d             = 1'b0;
    truncated_d        = 1'b0;
    n_proj_d           = '0;
    load               = 1'b0;
    ld_n               = n_tracklets;
    ld_bx              = bx_in;
    // Bit i of the valid pipe is a read issued i+1 cycles ago
    vld_d              = {vld_q[L-2:0], rd_en_q};
    wr_cnt_d           = wr_cnt_q;
    write_projection_d = write_projection_q;
    if (vld_d[L-1]) begin
      write_projection_d = wr_cnt_q;
      wr_cnt_d           = wr_cnt_q + ADDR_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (bx_start) load = 1'b1;
      end
      READ: begin
        if (bx_start) begin
          pend_vld_d = 1'b1;
          pend_n_d   = n_tracklets;
          pend_bx_d  = bx_in;
        end
        // A bx_start on the final read is just queued, not a truncation
        if (read_tracklet_q == n_q - ADDR_BITS'(1)) begin
          state_d = DRAIN;
        end else if (bx_start) begin
          state_d = DRAIN;
          trunc_d = 1'b1;
        end else begin
          rd_en_d         = 1'b1;
          read_tracklet_d = read_tracklet_q + ADDR_BITS'(1);
        end
      end
      DRAIN: begin
        if (bx_start) begin
          pend_vld_d = 1'b1;
          pend_n_d   = n_tracklets;
          pend_bx_d  = bx_in;
        end
        if (vld_d == '0) begin
          state_d     = DONE;
          done_d      = 1'b1;
          truncated_d = trunc_q;
          n_proj_d    = wr_cnt_d;
        end
      end
      default: begin
        trunc_d = 1'b0;
        // A bx_start landing in this cycle is newer than anything pending
        if (bx_start) begin
          load       = 1'b1;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          load       = 1'b1;
          ld_n       = pend_n_q;
          ld_bx      = pend_bx_q;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (load) begin
      n_d                = ld_n;
      bx_out_d           = ld_bx;
      wr_cnt_d           = '0;
      write_projection_d = '0;
      read_tracklet_d    = '0;
      if (ld_n != '0) begin
        state_d = READ;
        rd_en_d = 1'b1;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      n_q                <= '0;
      wr_cnt_q           <= '0;
      pend_n_q           <= '0;
      pend_bx_q          <= '0;
      pend_vld_q         <= 1'b0;
      trunc_q            <= 1'b0;
      vld_q              <= '0;
      read_tracklet_q    <= '0;
      rd_en_q            <= 1'b0;
      write_projection_q <= '0;
      bx_out_q           <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      truncated_q        <= 1'b0;
      n_proj_q           <= '0;
    end else begin
      state_q            <= state_d;
      n_q                <= n_d;
      wr_cnt_q           <= wr_cnt_d;
      pend_n_q           <= pend_n_d;
      pend_bx_q          <= pend_bx_d;
      pend_vld_q         <= pend_vld_d;
      trunc_q            <= trunc_d;
      vld_q              <= vld_d;
      read_tracklet_q    <= read_tracklet_d;
      rd_en_q            <= rd_en_d;
      write_projection_q <= write_projection_d;
      bx_out_q           <= bx_out_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      truncated_q        <= truncated_d;
      n_proj_q           <= n_proj_d;
    end
  end

  assign read_tracklet    = read_tracklet_q;
  assign rd_en            = rd_en_q;
  assign calc_valid       = vld_q[MEM_LATENCY-1];
  assign write_projection = write_projection_q;
  assign wr_en            = vld_q[L-1];
  assign bx_out           = bx_out_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign truncated        = truncated_q;
  assign n_proj           = n_proj_q;

endmodule
